regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write-port integer register file.
- Two combinational read ports and two synchronous write ports (ALU writeback A, load writeback B).
- Per-register busy scoreboard for hazard detection.
- Sequential clear engine that zeroes the file on a flush request.
- Sits between decode/issue and the writeback stages of the rv32 core.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (power of two, >=4); x0 hardwired zero.
- AW, $clog2(NREG), register address width (derived; do not override).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_addr  in  AW  read port 1 address.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs1_busy  out  1  busy bit of rs1_addr (combinational).
- rs2_addr  in  AW  read port 2 address.
- rs2_data  out  XLEN  read port 2 data (combinational).
- rs2_busy  out  1  busy bit of rs2_addr (combinational).
- wa_we  in  1  write enable, port A.
- wa_addr  in  AW  write address, port A.
- wa_data  in  XLEN  write data, port A.
- wb_we  in  1  write enable, port B.
- wb_addr  in  AW  write address, port B.
- wb_data  in  XLEN  write data, port B.
- iss_valid  in  1  instruction issued with a destination register.
- iss_rd  in  AW  destination of issued instruction.
- clr_req  in  1  single-cycle flush request.
- clr_busy  out  1  high while clear engine runs.
- clr_done  out  1  one-cycle pulse when clear completes.

Behaviour:
- Reset (async, rst=1): all registers=0, all busy=0, FSM=IDLE, clr_busy=0, clr_done=0. Reads during reset return 0.
- Reads: x0 always returns 0 with busy 0. Other addresses return the stored value, zero cycles of latency.
- Writes: committed at posedge when we=1 and addr!=0. Writes to x0 are dropped silently. Same-cycle A and B to the same addr: B wins.
- Scoreboard:
  - iss_valid && iss_rd!=0 sets busy[iss_rd] at posedge.
  - Any committed write on A or B clears busy[addr].
  - Set and clear of the same register in the same cycle: set wins (a newer producer is outstanding).
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 -> CLEAR, idx<=1.
  - CLEAR: clr_busy=1. Each cycle zeroes reg[idx] and busy[idx], idx++. When idx==NREG-1 is written -> DONE. Total NREG-1 cycles in CLEAR.
  - DONE: clr_done=1 for one cycle, clr_busy=0 -> IDLE.
  - clr_req outside IDLE is ignored.
  - While clr_busy=1: wa/wb writes and iss_valid are dropped (no state change). Reads return the current partially cleared contents.
- idx width AW, so no wrap-around past NREG-1.
- rst asserted mid-CLEAR: immediate return to IDLE with all state zeroed, no clr_done pulse.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When a read address matches a same-cycle write (we=1, addr!=0), rs*_data returns the write data, with B taking priority over A. rs*_busy returns 0 if that write clears the bit and there is no same-cycle set.
- Not defined: a read returns the old value, and the new value is visible from the cycle after the write edge.
- Forwarding is disabled while clr_busy=1.

Test Plan:
- Reset then A writes x1=0x12345678, B writes x2=0x87654321 same cycle -> next cycle rs1(x1)=0x12345678, rs2(x2)=0x87654321.
- A and B both write x5 (A=0xAAAA0000, B=0xBBBB0000) -> x5=0xBBBB0000. A writes x0=0xFFFFFFFF -> rs1(x0)=0, rs1_busy=0.
- iss x7 -> rs1_busy(x7)=1 next cycle. Then in one cycle A writes x7=0x11 while iss x7 -> busy stays 1, x7=0x11. Then A writes x7 alone -> busy=0.
- Load x1..x31 with 0xA5A5A5A5, pulse clr_req -> clr_busy high exactly 31 cycles, clr_done one pulse, all reads 0. Write to x3 during clear has no effect.
- Assert rst at cycle 10 of a clear -> clr_busy=0 immediately, no clr_done, all regs 0. Post-reset write x4=0x4 reads back 0x4.
- REGFILE_BYPASS_EN: read x9 while A writes x9=0xCAFEF00D -> same-cycle rs1_data=0xCAFEF00D. Without the macro -> old value 0, new value the next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port rv32 register file: 2 comb read ports, 2 write ports (B beats A), busy scoreboard, sequential flush engine.
// Reads: zero cycles of latency (write-through forwarding when REGFILE_BYPASS_EN is defined). No backpressure; writes/issues are dropped while clr_busy.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic            rs1_busy,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs2_busy,
    input  logic            wa_we,
    input  logic [AW-1:0]   wa_addr,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                      state, state_nxt;
    logic [AW-1:0]               idx, idx_nxt;
    logic [NREG-1:0][XLEN-1:0]   regs;
    logic [NREG-1:0]             busy, busy_nxt;
    logic                        clearing;
    logic                        wa_commit, wb_commit, iss_set;

    assign clearing  = (state == CLEAR);
    assign clr_busy  = clearing;
    assign clr_done  = (state == DONE);

    // Everything that changes architectural state is gated off while the clear engine owns the file.
    assign wa_commit = wa_we     && (wa_addr != '0) && !clearing;
    assign wb_commit = wb_we     && (wb_addr != '0) && !clearing;
    assign iss_set   = iss_valid && (iss_rd  != '0) && !clearing;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = AW'(1);
                end
            end
            CLEAR: begin
                if (idx == AW'(NREG - 1)) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + AW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Entry 0 is never written (commits exclude addr 0, the clear index starts at 1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (clearing) begin
            regs[idx] <= '0;
        end else begin
            if (wa_commit) regs[wa_addr] <= wa_data;
            if (wb_commit) regs[wb_addr] <= wb_data;
        end
    end

    // A same-cycle issue marks a newer producer, so the set is applied after the write clears.
    always_comb begin
        busy_nxt = busy;
        if (clearing) begin
            busy_nxt[idx] = 1'b0;
        end else begin
            if (wa_commit) busy_nxt[wa_addr] = 1'b0;
            if (wb_commit) busy_nxt[wb_addr] = 1'b0;
            if (iss_set)   busy_nxt[iss_rd]  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        rs1_busy = (rs1_addr == '0) ? 1'b0 : busy[rs1_addr];
`ifdef REGFILE_BYPASS_EN
        if (wb_commit && (wb_addr == rs1_addr)) begin
            rs1_data = wb_data;
        end else if (wa_commit && (wa_addr == rs1_addr)) begin
            rs1_data = wa_data;
        end
        if (((wa_commit && (wa_addr == rs1_addr)) || (wb_commit && (wb_addr == rs1_addr)))
            && !(iss_set && (iss_rd == rs1_addr))) begin
            rs1_busy = 1'b0;
        end
`endif
    end

    always_comb begin
        rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
        rs2_busy = (rs2_addr == '0) ? 1'b0 : busy[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wb_commit && (wb_addr == rs2_addr)) begin
            rs2_data = wb_data;
        end else if (wa_commit && (wa_addr == rs2_addr)) begin
            rs2_data = wa_data;
        end
        if (((wa_commit && (wa_addr == rs2_addr)) || (wb_commit && (wb_addr == rs2_addr)))
            && !(iss_set && (iss_rd == rs2_addr))) begin
            rs2_busy = 1'b0;
        end
`endif
    end

endmodule
